// File: rtl/midi_pkg.sv
// Shared MIDI message types and status codes used by the reader and the voice allocator.
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_OFF = 4'd0;
    localparam logic [3:0] MIDI_NOTE_ON  = 4'd1;

    typedef struct packed {
        logic [3:0] status;
        logic [7:0] note;
        logic [7:0] vel;
    } midi_msg_t;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} alloc_state_t;

endpackage

// File: rtl/midi_msg_skid.sv
// One-deep pending message buffer; a push while full (and not draining) is lost and flagged.
module midi_msg_skid
    import midi_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      push_in,
    input  midi_msg_t msg_in,
    input  logic      pop_in,
    output midi_msg_t msg_out,
    output logic      pending_out,
    output logic      drop_out
);

    midi_msg_t msg_q;
    logic      full_q;
    logic      drop_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            msg_q  <= '0;
            full_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (pop_in) begin
                full_q <= 1'b0;
            end
            // A push in the same cycle as the drain takes the freed slot.
            if (push_in) begin
                if (full_q && !pop_in) begin
                    drop_q <= 1'b1;
                end else begin
                    msg_q  <= msg_in;
                    full_q <= 1'b1;
                end
            end
        end
    end

    assign msg_out     = msg_q;
    assign pending_out = full_q;
    assign drop_out    = drop_q;

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: serial scan for match/free/oldest voice, then a one-cycle commit.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SEQ_W      = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [3:0]                  status_in,
    input  logic [7:0]                  data_byte1_in,
    input  logic [7:0]                  data_byte2_in,
    input  logic                        valid_in,
    output logic [NUM_VOICES-1:0][7:0]  voice_note_out,
    output logic [NUM_VOICES-1:0][7:0]  voice_vel_out,
    output logic [NUM_VOICES-1:0]       voice_gate_out,
    output logic [NUM_VOICES-1:0]       voice_trig_out,
    output logic                        busy_out,
    output logic                        drop_out
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    alloc_state_t                      state_q, state_d;
    logic                              valid_q;
    midi_msg_t                         cls_msg, pend_msg, work_q;
    logic                              push, pop, pending;
    logic [IDX_W-1:0]                  idx_q, target;
    logic                              match_found_q, free_found_q;
    logic [IDX_W-1:0]                  match_idx_q, free_idx_q, oldest_idx_q;
    logic [SEQ_W-1:0]                  oldest_age_q, age, seq_q;
    logic [NUM_VOICES-1:0][SEQ_W-1:0]  voice_seq_q;
    logic [NUM_VOICES-1:0][7:0]        note_q, vel_q;
    logic [NUM_VOICES-1:0]             gate_q, trig_q;

    // Note-on with zero velocity is folded into note-off before buffering.
    always_comb begin
        cls_msg.note   = data_byte1_in & 8'h7F;
        cls_msg.vel    = data_byte2_in & 8'h7F;
        cls_msg.status = (status_in == MIDI_NOTE_ON && cls_msg.vel != 8'd0) ?
                         MIDI_NOTE_ON : MIDI_NOTE_OFF;
    end

    assign push = valid_in && !valid_q &&
                  (status_in == MIDI_NOTE_ON || status_in == MIDI_NOTE_OFF);
    assign pop  = (state_q == IDLE) && pending;

    midi_msg_skid u_skid (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .push_in     (push),
        .msg_in      (cls_msg),
        .pop_in      (pop),
        .msg_out     (pend_msg),
        .pending_out (pending),
        .drop_out    (drop_out)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pending) state_d = SCAN;
            SCAN:    if (idx_q == IDX_W'(NUM_VOICES - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Age is modular so the ordering survives the sequence counter wrapping.
    assign age    = seq_q - voice_seq_q[idx_q];
    assign target = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : oldest_idx_q);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            valid_q       <= 1'b0;
            work_q        <= '0;
            idx_q         <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            oldest_idx_q  <= '0;
            oldest_age_q  <= '0;
            seq_q         <= '0;
            voice_seq_q   <= '0;
            note_q        <= '0;
            vel_q         <= '0;
            gate_q        <= '0;
            trig_q        <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_in;
            trig_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        work_q        <= pend_msg;
                        idx_q         <= '0;
                        match_found_q <= 1'b0;
                        free_found_q  <= 1'b0;
                        match_idx_q   <= '0;
                        free_idx_q    <= '0;
                        oldest_idx_q  <= '0;
                        oldest_age_q  <= '0;
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + 1'b1;
                    if (!match_found_q && gate_q[idx_q] && note_q[idx_q] == work_q.note) begin
                        match_found_q <= 1'b1;
                        match_idx_q   <= idx_q;
                    end
                    if (!free_found_q && !gate_q[idx_q]) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= idx_q;
                    end
                    if (age > oldest_age_q) begin
                        oldest_age_q <= age;
                        oldest_idx_q <= idx_q;
                    end
                end
                COMMIT: begin
                    if (work_q.status == MIDI_NOTE_ON) begin
                        note_q[target]      <= work_q.note;
                        vel_q[target]       <= work_q.vel;
                        gate_q[target]      <= 1'b1;
                        trig_q[target]      <= 1'b1;
                        voice_seq_q[target] <= seq_q;
                        seq_q               <= seq_q + 1'b1;
                    end else if (match_found_q) begin
                        gate_q[match_idx_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign voice_note_out = note_q;
    assign voice_vel_out  = vel_q;
    assign voice_gate_out = gate_q;
    assign voice_trig_out = trig_q;
    assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench: stimulus queues expected voice events, a monitor checks them as they appear.
module tb_midi_voice_allocator;

    localparam int NV = 4;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic [3:0]        status_in = '0;
    logic [7:0]        data_byte1_in = '0;
    logic [7:0]        data_byte2_in = '0;
    logic              valid_in = 1'b0;
    logic [NV-1:0][7:0] voice_note_out, voice_vel_out;
    logic [NV-1:0]     voice_gate_out, voice_trig_out;
    logic              busy_out, drop_out;

    midi_voice_allocator #(.NUM_VOICES(NV), .SEQ_W(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .status_in      (status_in),
        .data_byte1_in  (data_byte1_in),
        .data_byte2_in  (data_byte2_in),
        .valid_in       (valid_in),
        .voice_note_out (voice_note_out),
        .voice_vel_out  (voice_vel_out),
        .voice_gate_out (voice_gate_out),
        .voice_trig_out (voice_trig_out),
        .busy_out       (busy_out),
        .drop_out       (drop_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         voice;
        logic [7:0] note;
        logic [7:0] vel;
        logic [3:0] gate;
        bit         trig;
    } exp_t;

    exp_t ev_q[$];
    int   drop_exp = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_ev(input int v, input logic [7:0] n, input logic [7:0] vl,
                             input logic [3:0] g, input bit t);
        exp_t e;
        e.voice = v; e.note = n; e.vel = vl; e.gate = g; e.trig = t;
        ev_q.push_back(e);
    endtask

    task automatic send(input logic [3:0] st, input logic [7:0] n, input logic [7:0] v);
        @(negedge clk_in);
        status_in = st; data_byte1_in = n; data_byte2_in = v; valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
    endtask

    task automatic settle();
        repeat (NV + 4) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    // Monitor: any trig pulse or gate change is a voice event; drop pulses are counted separately.
    initial begin
        logic [NV-1:0] prev_gate;
        exp_t          e;
        logic [3:0]    exp_trig;
        prev_gate = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                if (drop_out) begin
                    checks++;
                    if (drop_exp == 0) begin
                        failures++;
                        $display("FAIL drop_unexpected: got 1, expected 0 at %0t", $time);
                    end else begin
                        drop_exp--;
                    end
                end
                if (voice_trig_out != '0 || voice_gate_out != prev_gate) begin
                    if (ev_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_event: trig=%b gate=%b, expected none at %0t",
                                 voice_trig_out, voice_gate_out, $time);
                    end else begin
                        e = ev_q.pop_front();
                        exp_trig = e.trig ? (4'b0001 << e.voice) : 4'b0000;
                        check("trig", 32'(voice_trig_out), 32'(exp_trig));
                        check("gate", 32'(voice_gate_out), 32'(e.gate));
                        check("note", 32'(voice_note_out[e.voice]), 32'(e.note));
                        check("vel", 32'(voice_vel_out[e.voice]), 32'(e.vel));
                    end
                end
            end
            prev_gate = voice_gate_out;
        end
    end

    initial begin
        int busy_cnt;
        int n;
        int budget;
        logic [3:0] g;

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_note", 32'(voice_note_out), 32'd0);
        check("rst_vel", 32'(voice_vel_out), 32'd0);
        check("rst_gate", 32'(voice_gate_out), 32'd0);
        check("rst_trig", 32'(voice_trig_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_drop", 32'(drop_out), 32'd0);
        rst_in = 1'b1;

        // First note-on: latency, trig width and busy length
        @(negedge clk_in);
        expect_ev(0, 8'd60, 8'd100, 4'b0001, 1'b1);
        status_in = 4'd1; data_byte1_in = 8'd60; data_byte2_in = 8'd100; valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_in);
            #1;
            if (busy_out) busy_cnt++;
            if (k == NV + 1) check("gate_early", 32'(voice_gate_out[0]), 32'd0);
            if (k == NV + 2) check("gate_at_latency", 32'(voice_gate_out[0]), 32'd1);
            if (k == NV + 2) check("trig_at_latency", 32'(voice_trig_out), 32'd1);
            if (k == NV + 3) check("trig_cleared", 32'(voice_trig_out), 32'd0);
        end
        check("busy_cycles", 32'(busy_cnt), 32'(NV + 1));

        // Fill all voices then steal the oldest
        do_reset();
        expect_ev(0, 8'd60, 8'd10, 4'b0001, 1'b1); send(4'd1, 8'd60, 8'd10); settle();
        expect_ev(1, 8'd62, 8'd20, 4'b0011, 1'b1); send(4'd1, 8'd62, 8'd20); settle();
        expect_ev(2, 8'd64, 8'd30, 4'b0111, 1'b1); send(4'd1, 8'd64, 8'd30); settle();
        expect_ev(3, 8'd65, 8'd40, 4'b1111, 1'b1); send(4'd1, 8'd65, 8'd40); settle();
        expect_ev(0, 8'd67, 8'd50, 4'b1111, 1'b1); send(4'd1, 8'd67, 8'd50); settle();

        // Release by zero velocity, then reuse of the freed voice; bit 7 of data bytes ignored
        do_reset();
        expect_ev(0, 8'd60, 8'd100, 4'b0001, 1'b1); send(4'd1, 8'd60, 8'd100); settle();
        expect_ev(0, 8'd60, 8'd100, 4'b0000, 1'b0); send(4'd1, 8'd60, 8'd0); settle();
        expect_ev(0, 8'd60, 8'd80, 4'b0001, 1'b1); send(4'd1, 8'd188, 8'd208); settle();
        send(4'd0, 8'd61, 8'd0); settle(); // note-off with no match: no event
        expect_ev(0, 8'd60, 8'd80, 4'b0000, 1'b0); send(4'd0, 8'd60, 8'd33); settle();

        // Retrigger of a sounding note
        do_reset();
        expect_ev(0, 8'd60, 8'd50, 4'b0001, 1'b1); send(4'd1, 8'd60, 8'd50); settle();
        expect_ev(0, 8'd60, 8'd90, 4'b0001, 1'b1); send(4'd1, 8'd60, 8'd90); settle();

        // Three edges two cycles apart: third is dropped
        do_reset();
        expect_ev(0, 8'd70, 8'd10, 4'b0001, 1'b1);
        expect_ev(1, 8'd72, 8'd10, 4'b0011, 1'b1);
        drop_exp = 1;
        send(4'd1, 8'd70, 8'd10);
        send(4'd1, 8'd72, 8'd10);
        send(4'd1, 8'd74, 8'd10);
        repeat (3 * NV + 8) @(negedge clk_in);

        // Ignored status: no activity, no drop
        send(4'd3, 8'd40, 8'd40);
        @(negedge clk_in);
        check("ignored_busy", 32'(busy_out), 32'd0);
        settle();

        // Steal order across sequence counter wrap
        do_reset();
        for (int i = 0; i < NV + 259; i++) begin
            n = 20 + (i % 50);
            g = (i < NV) ? 4'((1 << (i + 1)) - 1) : 4'b1111;
            expect_ev(i % NV, 8'(n), 8'(1 + (i % 100)), g, 1'b1);
            send(4'd1, 8'(n), 8'(1 + (i % 100)));
            settle();
        end

        budget = 200;
        while ((ev_q.size() != 0 || drop_exp != 0) && budget > 0) begin
            @(negedge clk_in);
            budget--;
        end
        check("events_pending", 32'(ev_q.size()), 32'd0);
        check("drops_pending", 32'(drop_exp), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
